// File: rtl/npc_unit.sv
// Next-PC generator and PC register for the MIPS fetch stage.
// Optional branch delay slot enabled by defining NPC_DELAY_SLOT_EN.
module npc_unit #(
    parameter int unsigned AW       = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic [1:0]    ctl,
    input  logic          br_taken,
    input  logic [25:0]   j_index,
    input  logic [15:0]   br_off,
    input  logic [AW-1:0] rs_val,
    input  logic          exc_req,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_plus4,
    output logic          redirect,
    output logic          misalign
);

    logic [AW-1:0] pc_d;
    logic          redirect_d;
    logic          misalign_d;
    logic [AW-1:0] jdir;
    logic [AW-1:0] jreg;
    logic [AW-1:0] br_tgt;
    logic [AW-1:0] xfer_tgt;
    logic [31:0]   br_disp;
    logic          xfer_req;
    logic          jr_bad;

    assign pc_plus4 = pc + AW'(4);
    assign br_disp  = {{14{br_off[15]}}, br_off, 2'b00};
    assign br_tgt   = pc_plus4 + br_disp[AW-1:0];
    assign jreg     = {rs_val[AW-1:2], 2'b00};

    // Narrow builds have no region bits above the 28-bit jump field.
    generate
        if (AW > 28) begin : g_jdir_region
            assign jdir = {pc_plus4[AW-1:28], j_index, 2'b00};
        end else begin : g_jdir_trunc
            logic [27:0] jfull;
            assign jfull = {j_index, 2'b00};
            assign jdir  = jfull[AW-1:0];
        end
    endgenerate

    always_comb begin
        xfer_req = (ctl == 2'b01) || (ctl == 2'b10) || ((ctl == 2'b11) && br_taken);
        jr_bad   = (ctl == 2'b10) && (rs_val[1:0] != 2'b00);
        case (ctl)
            2'b01:   xfer_tgt = jdir;
            2'b10:   xfer_tgt = jreg;
            default: xfer_tgt = br_tgt;
        endcase
    end

`ifdef NPC_DELAY_SLOT_EN
    typedef enum logic {SLOT_NONE, SLOT_PENDING} slot_t;
    slot_t         slot_q, slot_d;
    logic [AW-1:0] tgt_q, tgt_d;

    always_comb begin
        pc_d       = pc_plus4;
        redirect_d = 1'b0;
        misalign_d = 1'b0;
        slot_d     = slot_q;
        tgt_d      = tgt_q;
        if (exc_req) begin
            pc_d       = EXC_PC[AW-1:0];
            redirect_d = 1'b1;
            slot_d     = SLOT_NONE;
        end else if (stall) begin
            pc_d = pc;
        end else if (slot_q == SLOT_PENDING) begin
            // Delay slot done: new requests are ignored while the target is queued.
            pc_d       = tgt_q;
            redirect_d = 1'b1;
            slot_d     = SLOT_NONE;
        end else if (xfer_req) begin
            tgt_d      = xfer_tgt;
            slot_d     = SLOT_PENDING;
            misalign_d = jr_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q <= SLOT_NONE;
            tgt_q  <= '0;
        end else begin
            slot_q <= slot_d;
            tgt_q  <= tgt_d;
        end
    end
`else
    always_comb begin
        pc_d       = pc_plus4;
        redirect_d = 1'b0;
        misalign_d = 1'b0;
        if (exc_req) begin
            pc_d       = EXC_PC[AW-1:0];
            redirect_d = 1'b1;
        end else if (stall) begin
            pc_d = pc;
        end else if (xfer_req) begin
            pc_d       = xfer_tgt;
            redirect_d = 1'b1;
            misalign_d = jr_bad;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC[AW-1:0];
            redirect <= 1'b0;
            misalign <= 1'b0;
        end else begin
            pc       <= pc_d;
            redirect <= redirect_d;
            misalign <= misalign_d;
        end
    end

endmodule

// File: tb/tb_npc_unit.sv
// Scoreboard bench for npc_unit: a behavioural next-PC model pushes expected
// state per cycle; results are popped and compared one cycle later.
module tb_npc_unit;

    logic        clk = 1'b0;
    logic        rst_n, stall, br_taken, exc_req;
    logic [1:0]  ctl;
    logic [25:0] j_index;
    logic [15:0] br_off;
    logic [31:0] rs_val;
    logic [31:0] pc, pc_plus4;
    logic        redirect, misalign;

    logic        w_rst_n;
    logic        w_zero  = 1'b0;
    logic [1:0]  w_ctl   = 2'b00;
    logic [25:0] w_ji    = '0;
    logic [15:0] w_off   = '0;
    logic [31:0] w_rs    = '0;
    logic [31:0] w_pc, w_pc4;
    logic        w_redir, w_mis;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    typedef struct {
        logic [31:0] pc;
        logic        redir;
        logic        mis;
    } exp_t;
    exp_t sb[$];

    logic [31:0] m_pc;
`ifdef NPC_DELAY_SLOT_EN
    logic        m_pend;
    logic [31:0] m_tgt;
`endif

    always #5 clk = ~clk;

    npc_unit #(.AW(32), .RESET_PC(32'h0000_3000), .EXC_PC(32'h0000_4180)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .ctl(ctl), .br_taken(br_taken),
        .j_index(j_index), .br_off(br_off), .rs_val(rs_val), .exc_req(exc_req),
        .pc(pc), .pc_plus4(pc_plus4), .redirect(redirect), .misalign(misalign)
    );

    npc_unit #(.AW(32), .RESET_PC(32'hFFFF_FFFC), .EXC_PC(32'h0000_4180)) u_wrap (
        .clk(clk), .rst_n(w_rst_n), .stall(w_zero), .ctl(w_ctl), .br_taken(w_zero),
        .j_index(w_ji), .br_off(w_off), .rs_val(w_rs), .exc_req(w_zero),
        .pc(w_pc), .pc_plus4(w_pc4), .redirect(w_redir), .misalign(w_mis)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, predict the post-edge state, compare it after the edge.
    task automatic step(input logic r, input logic st, input logic [1:0] c, input logic bt,
                        input logic [25:0] ji, input logic [15:0] bo, input logic [31:0] rs,
                        input logic ex);
        logic [31:0] seq, tgt;
        logic        xfer;
        exp_t        e, g;
        rst_n = r; stall = st; ctl = c; br_taken = bt;
        j_index = ji; br_off = bo; rs_val = rs; exc_req = ex;

        seq  = m_pc + 32'd4;
        xfer = (c == 2'b01) || (c == 2'b10) || (c == 2'b11 && bt);
        if (c == 2'b01)      tgt = {seq[31:28], ji, 2'b00};
        else if (c == 2'b10) tgt = {rs[31:2], 2'b00};
        else                 tgt = seq + {{14{bo[15]}}, bo, 2'b00};
        e.redir = 1'b0;
        e.mis   = 1'b0;
        if (!r) begin
            m_pc = 32'h0000_3000;
`ifdef NPC_DELAY_SLOT_EN
            m_pend = 1'b0; m_tgt = '0;
`endif
        end else if (ex) begin
            m_pc = 32'h0000_4180; e.redir = 1'b1;
`ifdef NPC_DELAY_SLOT_EN
            m_pend = 1'b0;
`endif
        end else if (st) begin
            m_pc = m_pc;
`ifdef NPC_DELAY_SLOT_EN
        end else if (m_pend) begin
            m_pc = m_tgt; m_pend = 1'b0; e.redir = 1'b1;
        end else if (xfer) begin
            m_tgt = tgt; m_pend = 1'b1; m_pc = seq;
            e.mis = (c == 2'b10) && (rs[1:0] != 2'b00);
`else
        end else if (xfer) begin
            m_pc = tgt; e.redir = 1'b1;
            e.mis = (c == 2'b10) && (rs[1:0] != 2'b00);
`endif
        end else begin
            m_pc = seq;
        end
        e.pc = m_pc;
        sb.push_back(e);

        @(posedge clk);
        #1;
        g = sb.pop_front();
        check_val("pc", pc, g.pc);
        check_val("pc_plus4", pc_plus4, g.pc + 32'd4);
        check_val("redirect", {31'd0, redirect}, {31'd0, g.redir});
        check_val("misalign", {31'd0, misalign}, {31'd0, g.mis});
    endtask

    task automatic seq_step();
        step(1'b1, 1'b0, 2'b00, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic goto_3010();
        step(1'b0, 1'b0, 2'b00, 1'b0, '0, '0, '0, 1'b0);
        repeat (4) seq_step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_pc = '0;
`ifdef NPC_DELAY_SLOT_EN
        m_pend = 1'b0; m_tgt = '0;
`endif
        w_rst_n = 1'b0;
        @(negedge clk);

        // Reset held two cycles with a jump request present
        step(1'b0, 1'b0, 2'b01, 1'b0, 26'h0000C40, '0, '0, 1'b0);
        step(1'b0, 1'b0, 2'b01, 1'b0, 26'h0000C40, '0, '0, 1'b0);
        check_val("rst_pc", pc, 32'h0000_3000);
        check_val("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
        check_val("wrap_rst_pc4", w_pc4, 32'h0);
        w_rst_n = 1'b1;
        seq_step();
        check_val("wrap_pc0", w_pc, 32'h0);
        check_val("wrap_redirect", {31'd0, w_redir}, 32'd0);
        seq_step();
        check_val("seq_3008", pc, 32'h0000_3008);
        check_val("wrap_pc4", w_pc, 32'h4);
        check_val("wrap_mis", {31'd0, w_mis}, 32'd0);

        // J
        step(1'b1, 1'b0, 2'b01, 1'b0, 26'h0000C40, '0, '0, 1'b0);
`ifdef NPC_DELAY_SLOT_EN
        check_val("j_slot", pc, 32'h0000_300C);
        seq_step();
`endif
        check_val("j_target", pc, 32'h0000_3100);
        check_val("j_redirect", {31'd0, redirect}, 32'd1);
        seq_step();
        check_val("j_redirect_drop", {31'd0, redirect}, 32'd0);

        // Taken / not-taken branch at 0x3010
        goto_3010();
        step(1'b1, 1'b0, 2'b11, 1'b1, '0, 16'hFFFC, '0, 1'b0);
`ifdef NPC_DELAY_SLOT_EN
        seq_step();
`endif
        check_val("br_taken", pc, 32'h0000_3004);
        goto_3010();
        step(1'b1, 1'b0, 2'b11, 1'b0, '0, 16'hFFFC, '0, 1'b0);
        check_val("br_not_taken", pc, 32'h0000_3014);
        check_val("br_nt_redirect", {31'd0, redirect}, 32'd0);

        // JR misaligned, stalled then accepted
        step(1'b1, 1'b1, 2'b10, 1'b0, '0, '0, 32'h0000_5007, 1'b0);
        check_val("jr_stall_pc", pc, 32'h0000_3014);
        check_val("jr_stall_mis", {31'd0, misalign}, 32'd0);
        step(1'b1, 1'b0, 2'b10, 1'b0, '0, '0, 32'h0000_5007, 1'b0);
        check_val("jr_mis", {31'd0, misalign}, 32'd1);
`ifdef NPC_DELAY_SLOT_EN
        seq_step();
`endif
        check_val("jr_target", pc, 32'h0000_5004);
        seq_step();
        check_val("jr_mis_drop", {31'd0, misalign}, 32'd0);

        // Exception wins over stall and jump
        step(1'b1, 1'b1, 2'b01, 1'b0, 26'h0000C40, '0, '0, 1'b1);
        check_val("exc_pc", pc, 32'h0000_4180);
        check_val("exc_redirect", {31'd0, redirect}, 32'd1);

        // Exception and reset while a transfer is queued
        step(1'b1, 1'b0, 2'b01, 1'b0, 26'h0000C40, '0, '0, 1'b0);
        step(1'b1, 1'b0, 2'b00, 1'b0, '0, '0, '0, 1'b1);
        seq_step();
        check_val("exc_drop_pending", pc, 32'h0000_4184);
        step(1'b1, 1'b0, 2'b01, 1'b0, 26'h0000C40, '0, '0, 1'b0);
        step(1'b0, 1'b0, 2'b00, 1'b0, '0, '0, '0, 1'b0);
        seq_step();
        check_val("rst_drop_pending", pc, 32'h0000_3004);
        check_val("rst_drop_redirect", {31'd0, redirect}, 32'd0);

        // Random mix
        for (int unsigned i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 5) == 0),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 26'($urandom), 16'($urandom), $urandom, ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
